// File: rtl/add_sub_rs_pkg.sv
// add_sub_rs_pkg
//   Shared types and helpers for the add/subtract reservation station.
//   - add_sub_decode_t : decoded control word carried alongside the operands
//   - rs_entry_state_t : lifecycle of one station entry (FREE/WAIT/ISSUED)
//   - lowest_set       : priority encoder (lowest set bit wins) used for both
//                        free-entry allocation and ready-entry dispatch
package add_sub_rs_pkg;

   // Upper bound on entries; selection vectors are padded to this width so a
   // single encoder serves every legal depth.
   localparam int MAX_DEPTH = 8;
   localparam int IDX_W     = 3;

   typedef struct packed {
      logic subtract;  // compute op2 - op1 instead of op1 + op2
      logic carry_in;  // add XER[CA] into the sum
      logic set_ca;    // update XER[CA] from the result
      logic set_ov;    // update XER[OV]/[SO] from the result
      logic set_cr0;   // record form, update CR0
   } add_sub_decode_t;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ISSUED = 2'd2
   } rs_entry_state_t;

   // Index of the lowest set bit; 0 when no bit is set, so callers must
   // qualify the result with a reduction-OR of the same vector.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_DEPTH-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/add_sub_rs_if.sv
// add_sub_rs_if
//   Bundles everything around the reservation station except clk/rst:
//   decode-side allocation port, CDB snoop port and dispatch port toward
//   add_sub_unit.
//   Modports:
//     slave  - the reservation station's view
//     master - the surrounding pipeline's view (decode, CDB, add_sub_unit)
//
//   Handshakes (input_valid/input_ready and output_valid/output_ready):
//   a transfer happens on a rising clk edge where valid and ready are both 1.
//   A valid offer with ready low is held stable by its source until taken;
//   ready may be high with valid low. Neither side may make valid depend
//   combinationally on the other side's ready.
interface add_sub_rs_if #(
   parameter int RS_ID_WIDTH = 5
);
   import add_sub_rs_pkg::*;

   // decode -> station
   logic                   input_valid;
   logic                   input_ready;
   logic [4:0]             result_reg_addr_in;
   add_sub_decode_t        control_in;
   logic [31:0]            op1_in;
   logic [31:0]            op2_in;
   logic [31:0]            xer_in;
   logic                   op1_valid_in;
   logic                   op2_valid_in;
   logic                   xer_valid_in;
   logic [RS_ID_WIDTH-1:0] op1_tag_in;
   logic [RS_ID_WIDTH-1:0] op2_tag_in;
   logic [RS_ID_WIDTH-1:0] xer_tag_in;

   // common data bus
   logic                   cdb_valid;
   logic [RS_ID_WIDTH-1:0] cdb_rs_id;
   logic [31:0]            cdb_result;
   logic [31:0]            cdb_xer;

   // station -> add_sub_unit
   logic                   output_valid;
   logic                   output_ready;
   logic [RS_ID_WIDTH-1:0] rs_id_out;
   logic [4:0]             result_reg_addr_out;
   logic [31:0]            op1_out;
   logic [31:0]            op2_out;
   logic [31:0]            xer_out;
   add_sub_decode_t        control_out;

   modport slave (
      input  input_valid, result_reg_addr_in, control_in,
      input  op1_in, op2_in, xer_in,
      input  op1_valid_in, op2_valid_in, xer_valid_in,
      input  op1_tag_in, op2_tag_in, xer_tag_in,
      input  cdb_valid, cdb_rs_id, cdb_result, cdb_xer,
      input  output_ready,
      output input_ready,
      output output_valid, rs_id_out, result_reg_addr_out,
      output op1_out, op2_out, xer_out, control_out
   );

   modport master (
      output input_valid, result_reg_addr_in, control_in,
      output op1_in, op2_in, xer_in,
      output op1_valid_in, op2_valid_in, xer_valid_in,
      output op1_tag_in, op2_tag_in, xer_tag_in,
      output cdb_valid, cdb_rs_id, cdb_result, cdb_xer,
      output output_ready,
      input  input_ready,
      input  output_valid, rs_id_out, result_reg_addr_out,
      input  op1_out, op2_out, xer_out, control_out
   );

endinterface

// File: rtl/add_sub_rs_operand_slot.sv
// rs_operand_slot
//   One operand register of a reservation-station entry.
//   Ports:
//     clk, rst            clock, synchronous active-high reset (clears slot)
//     load                entry is being allocated this cycle
//     load_value/valid/tag operand as delivered by decode
//     snoop_en            entry is in WAIT, so CDB wakeup is permitted
//     cdb_valid/rs_id/value CDB broadcast (value is result or XER per slot)
//     value, valid        registered operand value and presence bit
module rs_operand_slot #(
   parameter int RS_ID_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [31:0]            load_value,
   input  logic                   load_valid,
   input  logic [RS_ID_WIDTH-1:0] load_tag,
   input  logic                   snoop_en,
   input  logic                   cdb_valid,
   input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
   input  logic [31:0]            cdb_value,
   output logic [31:0]            value,
   output logic                   valid
);

   logic [RS_ID_WIDTH-1:0] tag;
   logic                   bypass_hit;
   logic                   snoop_hit;

   // A producer broadcasting in the allocation cycle would otherwise be
   // missed forever, so the incoming tag is compared against the CDB too.
   assign bypass_hit = cdb_valid && (cdb_rs_id == load_tag);
   assign snoop_hit  = snoop_en && !valid && cdb_valid && (cdb_rs_id == tag);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
         valid <= 1'b0;
         tag   <= '0;
      end else if (load) begin
         tag <= load_tag;
         if (load_valid) begin
            value <= load_value;
            valid <= 1'b1;
         end else if (bypass_hit) begin
            value <= cdb_value;
            valid <= 1'b1;
         end else begin
            value <= '0;
            valid <= 1'b0;
         end
      end else if (snoop_hit) begin
         value <= cdb_value;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/add_sub_rs.sv
// add_sub_rs
//   Reservation station in front of add_sub_unit. Entries are allocated from
//   decode, collect missing operands from the CDB, dispatch in lowest-index
//   order, and stay ISSUED until their own tag appears on the CDB so the
//   rs_id is never reused while the instruction is in flight.
//   Ports:
//     clk, rst         clock, synchronous active-high reset (flushes all entries)
//     bus              add_sub_rs_if.slave: allocation, CDB and dispatch
//     entry_state_dbg  per-entry lifecycle state, entry i at index i
module add_sub_rs
   import add_sub_rs_pkg::*;
#(
   parameter int RS_ID_WIDTH = 5,
   parameter int RS_OFFSET   = 0,
   parameter int RS_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   add_sub_rs_if.slave                    bus,
   output rs_entry_state_t [RS_DEPTH-1:0] entry_state_dbg
);

   rs_entry_state_t state      [RS_DEPTH];
   rs_entry_state_t state_next [RS_DEPTH];
   add_sub_decode_t control_q  [RS_DEPTH];
   logic [4:0]      dest_q     [RS_DEPTH];

   logic [31:0] op1_val [RS_DEPTH];
   logic [31:0] op2_val [RS_DEPTH];
   logic [31:0] xer_val [RS_DEPTH];
   logic [RS_DEPTH-1:0] op1_vld, op2_vld, xer_vld;

   logic [MAX_DEPTH-1:0] free_vec;
   logic [MAX_DEPTH-1:0] ready_vec;
   logic [RS_DEPTH-1:0]  alloc_sel;
   logic [RS_DEPTH-1:0]  wait_vec;
   logic [RS_DEPTH-1:0]  release_vec;
   logic [IDX_W-1:0]     alloc_idx;
   logic [IDX_W-1:0]     disp_idx;
   logic                 in_ready;
   logic                 any_ready;
   logic                 alloc_fire;
   logic                 disp_fire;

   // Readiness is judged from registered slots only, so an operand woken
   // this cycle dispatches next cycle and there is no CDB-to-dispatch path.
   always_comb begin
      free_vec  = '0;
      ready_vec = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         free_vec[i]  = (state[i] == ST_FREE);
         ready_vec[i] = (state[i] == ST_WAIT) && op1_vld[i] && op2_vld[i] && xer_vld[i];
      end
   end

   assign alloc_idx  = lowest_set(free_vec);
   assign disp_idx   = lowest_set(ready_vec);
   assign in_ready   = !rst && (|free_vec);
   assign any_ready  = !rst && (|ready_vec);
   assign alloc_fire = bus.input_valid && in_ready;
   assign disp_fire  = any_ready && bus.output_ready;

   for (genvar i = 0; i < RS_DEPTH; i++) begin : g_entry
      assign alloc_sel[i]   = alloc_fire && (alloc_idx == IDX_W'(i));
      assign wait_vec[i]    = (state[i] == ST_WAIT);
      // Only an in-flight entry can be released; a match on a WAIT or FREE
      // entry's own tag is a stale or foreign broadcast.
      assign release_vec[i] = (state[i] == ST_ISSUED) && bus.cdb_valid &&
                              (bus.cdb_rs_id == RS_ID_WIDTH'(RS_OFFSET + i));
      assign entry_state_dbg[i] = state[i];

      rs_operand_slot #(.RS_ID_WIDTH(RS_ID_WIDTH)) u_op1 (
         .clk(clk), .rst(rst), .load(alloc_sel[i]),
         .load_value(bus.op1_in), .load_valid(bus.op1_valid_in), .load_tag(bus.op1_tag_in),
         .snoop_en(wait_vec[i]), .cdb_valid(bus.cdb_valid), .cdb_rs_id(bus.cdb_rs_id),
         .cdb_value(bus.cdb_result), .value(op1_val[i]), .valid(op1_vld[i])
      );

      rs_operand_slot #(.RS_ID_WIDTH(RS_ID_WIDTH)) u_op2 (
         .clk(clk), .rst(rst), .load(alloc_sel[i]),
         .load_value(bus.op2_in), .load_valid(bus.op2_valid_in), .load_tag(bus.op2_tag_in),
         .snoop_en(wait_vec[i]), .cdb_valid(bus.cdb_valid), .cdb_rs_id(bus.cdb_rs_id),
         .cdb_value(bus.cdb_result), .value(op2_val[i]), .valid(op2_vld[i])
      );

      rs_operand_slot #(.RS_ID_WIDTH(RS_ID_WIDTH)) u_xer (
         .clk(clk), .rst(rst), .load(alloc_sel[i]),
         .load_value(bus.xer_in), .load_valid(bus.xer_valid_in), .load_tag(bus.xer_tag_in),
         .snoop_en(wait_vec[i]), .cdb_valid(bus.cdb_valid), .cdb_rs_id(bus.cdb_rs_id),
         .cdb_value(bus.cdb_xer), .value(xer_val[i]), .valid(xer_vld[i])
      );
   end

   // Entry lifecycle: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_DEPTH; i++) state[i] <= ST_FREE;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) state[i] <= state_next[i];
      end
   end

   // Entry lifecycle: next state. Allocation only targets FREE entries and
   // release only ISSUED ones, so the two can never collide on one entry.
   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         state_next[i] = state[i];
         case (state[i])
            ST_FREE:   if (alloc_sel[i]) state_next[i] = ST_WAIT;
            ST_WAIT:   if (disp_fire && (disp_idx == IDX_W'(i))) state_next[i] = ST_ISSUED;
            ST_ISSUED: if (release_vec[i]) state_next[i] = ST_FREE;
            default:   state_next[i] = ST_FREE;
         endcase
      end
   end

   // Non-operand payload of each entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            control_q[i] <= '0;
            dest_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (alloc_sel[i]) begin
               control_q[i] <= bus.control_in;
               dest_q[i]    <= bus.result_reg_addr_in;
            end
         end
      end
   end

   // Dispatch mux: outputs are zero whenever nothing is offered.
   logic [RS_ID_WIDTH-1:0] rs_id_mux;
   logic [4:0]             dest_mux;
   logic [31:0]            op1_mux, op2_mux, xer_mux;
   add_sub_decode_t        control_mux;

   always_comb begin
      rs_id_mux   = '0;
      dest_mux    = '0;
      op1_mux     = '0;
      op2_mux     = '0;
      xer_mux     = '0;
      control_mux = '0;
      if (any_ready) rs_id_mux = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(disp_idx);
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (any_ready && (disp_idx == IDX_W'(i))) begin
            dest_mux    = dest_q[i];
            op1_mux     = op1_val[i];
            op2_mux     = op2_val[i];
            xer_mux     = xer_val[i];
            control_mux = control_q[i];
         end
      end
   end

   assign bus.input_ready         = in_ready;
   assign bus.output_valid        = any_ready;
   assign bus.rs_id_out           = rs_id_mux;
   assign bus.result_reg_addr_out = dest_mux;
   assign bus.op1_out             = op1_mux;
   assign bus.op2_out             = op2_mux;
   assign bus.xer_out             = xer_mux;
   assign bus.control_out         = control_mux;

endmodule

// File: tb/tb_add_sub_rs.sv
// tb_add_sub_rs
//   Directed bench for add_sub_rs (RS_OFFSET=0, RS_DEPTH=4, RS_ID_WIDTH=5).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_add_sub_rs;
   import add_sub_rs_pkg::*;

   localparam int W = 5;
   localparam logic [7:0] ALL_FREE   = 8'h00;
   localparam logic [7:0] ALL_WAIT   = 8'h55;
   localparam logic [7:0] ALL_ISSUED = 8'hAA;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   add_sub_rs_if #(.RS_ID_WIDTH(W)) bus ();
   rs_entry_state_t [3:0] dbg;

   add_sub_rs #(.RS_ID_WIDTH(W), .RS_OFFSET(0), .RS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .bus(bus), .entry_state_dbg(dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   add_sub_decode_t ctl_add;
   add_sub_decode_t ctl_sub;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.input_valid        = 1'b0;
      bus.result_reg_addr_in = '0;
      bus.control_in         = '0;
      bus.op1_in = '0; bus.op2_in = '0; bus.xer_in = '0;
      bus.op1_valid_in = 1'b0; bus.op2_valid_in = 1'b0; bus.xer_valid_in = 1'b0;
      bus.op1_tag_in = '0; bus.op2_tag_in = '0; bus.xer_tag_in = '0;
      bus.cdb_valid = 1'b0; bus.cdb_rs_id = '0; bus.cdb_result = '0; bus.cdb_xer = '0;
   endtask

   // Offers one instruction for exactly one clock edge.
   task automatic alloc(input logic [31:0] a, input logic av, input logic [W-1:0] at,
                        input logic [31:0] b, input logic bv, input logic [W-1:0] bt,
                        input logic [31:0] x, input logic xv, input logic [W-1:0] xt,
                        input logic [4:0] dest, input add_sub_decode_t ctl);
      bus.input_valid = 1'b1;
      bus.op1_in = a; bus.op1_valid_in = av; bus.op1_tag_in = at;
      bus.op2_in = b; bus.op2_valid_in = bv; bus.op2_tag_in = bt;
      bus.xer_in = x; bus.xer_valid_in = xv; bus.xer_tag_in = xt;
      bus.result_reg_addr_in = dest;
      bus.control_in = ctl;
      tick();
      bus.input_valid = 1'b0;
      bus.op1_valid_in = 1'b0; bus.op2_valid_in = 1'b0; bus.xer_valid_in = 1'b0;
   endtask

   task automatic cdb(input logic [W-1:0] id, input logic [31:0] res, input logic [31:0] x);
      bus.cdb_valid = 1'b1; bus.cdb_rs_id = id; bus.cdb_result = res; bus.cdb_xer = x;
      tick();
      bus.cdb_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.output_ready = 1'b0;
      tick();
      tick();
      checks++; if (bus.input_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %0b want 0", bus.input_ready); end
      checks++; if (bus.output_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %0b want 0", bus.output_valid); end
      checks++; if (bus.op1_out !== 32'h0 || bus.rs_id_out !== 5'd0) begin failures++; $display("FAIL rst_data: got op1=%0h id=%0d want 0 0", bus.op1_out, bus.rs_id_out); end
      checks++; if (dbg !== ALL_FREE) begin failures++; $display("FAIL rst_state: got %0h want %0h", dbg, ALL_FREE); end
      rst = 1'b0;
      #1;
      checks++; if (bus.input_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %0b want 1", bus.input_ready); end
   endtask

   task automatic test_basic();
      bus.output_ready = 1'b1;
      alloc(32'd5, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd3, ctl_add);
      checks++; if (bus.output_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %0b want 1", bus.output_valid); end
      checks++; if (bus.rs_id_out !== 5'd0) begin failures++; $display("FAIL basic_id: got %0d want 0", bus.rs_id_out); end
      checks++; if (bus.op1_out !== 32'd5 || bus.op2_out !== 32'd3) begin failures++; $display("FAIL basic_ops: got %0h %0h want 5 3", bus.op1_out, bus.op2_out); end
      checks++; if (bus.result_reg_addr_out !== 5'd3 || bus.control_out !== ctl_add) begin failures++; $display("FAIL basic_ctl: got rt=%0d ctl=%0h want 3 %0h", bus.result_reg_addr_out, bus.control_out, ctl_add); end
      tick();
      checks++; if (dbg[0] !== ST_ISSUED || bus.output_valid !== 1'b0) begin failures++; $display("FAIL basic_issued: got st=%0d v=%0b want 2 0", dbg[0], bus.output_valid); end
      cdb(5'd4, 32'h0, 32'h0);
      checks++; if (dbg[0] !== ST_ISSUED) begin failures++; $display("FAIL basic_foreign_tag: got %0d want 2", dbg[0]); end
      cdb(5'd0, 32'd8, 32'h0);
      checks++; if (dbg !== ALL_FREE || bus.input_ready !== 1'b1) begin failures++; $display("FAIL basic_release: got st=%0h rdy=%0b want 0 1", dbg, bus.input_ready); end
   endtask

   task automatic test_wakeup();
      bus.output_ready = 1'b1;
      alloc(32'd1, 1'b1, 5'd0, 32'd0, 1'b0, 5'd7, 32'd0, 1'b1, 5'd0, 5'd4, ctl_sub);
      checks++; if (bus.output_valid !== 1'b0) begin failures++; $display("FAIL wake_blocked: got %0b want 0", bus.output_valid); end
      tick();
      checks++; if (bus.output_valid !== 1'b0 || dbg[0] !== ST_WAIT) begin failures++; $display("FAIL wake_still_wait: got v=%0b st=%0d want 0 1", bus.output_valid, dbg[0]); end
      cdb(5'd7, 32'h10, 32'h2000_0000);
      checks++; if (bus.output_valid !== 1'b1 || bus.rs_id_out !== 5'd0) begin failures++; $display("FAIL wake_dispatch: got v=%0b id=%0d want 1 0", bus.output_valid, bus.rs_id_out); end
      checks++; if (bus.op2_out !== 32'h10 || bus.xer_out !== 32'h0) begin failures++; $display("FAIL wake_value: got op2=%0h xer=%0h want 10 0", bus.op2_out, bus.xer_out); end
      tick();
      cdb(5'd0, 32'h0, 32'h0);
      checks++; if (dbg !== ALL_FREE) begin failures++; $display("FAIL wake_cleanup: got %0h want 0", dbg); end
   endtask

   task automatic test_bypass();
      bus.output_ready = 1'b1;
      bus.cdb_valid = 1'b1; bus.cdb_rs_id = 5'd9; bus.cdb_result = 32'hFFFF_FFFF; bus.cdb_xer = 32'h8000_0000;
      alloc(32'd0, 1'b0, 5'd9, 32'd2, 1'b1, 5'd0, 32'd0, 1'b0, 5'd9, 5'd5, ctl_add);
      bus.cdb_valid = 1'b0;
      checks++; if (bus.output_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid: got %0b want 1", bus.output_valid); end
      checks++; if (bus.op1_out !== 32'hFFFF_FFFF || bus.xer_out !== 32'h8000_0000) begin failures++; $display("FAIL bypass_value: got op1=%0h xer=%0h want ffffffff 80000000", bus.op1_out, bus.xer_out); end
      tick();
      cdb(5'd0, 32'h0, 32'h0);
   endtask

   task automatic test_full_order();
      bus.output_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         alloc(32'h100 + i, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'(i), ctl_add);
      checks++; if (bus.input_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %0b want 0", bus.input_ready); end
      alloc(32'h555, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd31, ctl_sub);
      checks++; if (dbg !== ALL_WAIT || bus.op1_out !== 32'h100 || bus.rs_id_out !== 5'd0) begin failures++; $display("FAIL full_ignored: got st=%0h op1=%0h id=%0d want 55 100 0", dbg, bus.op1_out, bus.rs_id_out); end
      bus.output_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (bus.output_valid !== 1'b1 || bus.rs_id_out !== 5'(k) || bus.op1_out !== 32'h100 + k) begin failures++; $display("FAIL order_%0d: got v=%0b id=%0d op1=%0h want 1 %0d %0h", k, bus.output_valid, bus.rs_id_out, bus.op1_out, k, 32'h100 + k); end
         tick();
      end
      checks++; if (bus.output_valid !== 1'b0 || dbg !== ALL_ISSUED) begin failures++; $display("FAIL order_drained: got v=%0b st=%0h want 0 aa", bus.output_valid, dbg); end
      cdb(5'd2, 32'h0, 32'h0);
      checks++; if (dbg[2] !== ST_FREE || bus.input_ready !== 1'b1) begin failures++; $display("FAIL release2: got st=%0d rdy=%0b want 0 1", dbg[2], bus.input_ready); end
      bus.output_ready = 1'b0;
      alloc(32'h222, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd9, ctl_add);
      checks++; if (dbg[2] !== ST_WAIT || bus.rs_id_out !== 5'd2 || bus.op1_out !== 32'h222) begin failures++; $display("FAIL realloc2: got st=%0d id=%0d op1=%0h want 1 2 222", dbg[2], bus.rs_id_out, bus.op1_out); end
      bus.output_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) cdb(5'(i), 32'h0, 32'h0);
      checks++; if (dbg !== ALL_FREE) begin failures++; $display("FAIL full_cleanup: got %0h want 0", dbg); end
   endtask

   task automatic test_hold_priority();
      bus.output_ready = 1'b0;
      alloc(32'd0,  1'b0, 5'd12, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd1, ctl_add);
      alloc(32'h11, 1'b1, 5'd0,  32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd2, ctl_add);
      alloc(32'd0,  1'b0, 5'd13, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd3, ctl_add);
      alloc(32'h33, 1'b1, 5'd0,  32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd4, ctl_add);
      for (int c = 0; c < 3; c++) begin
         checks++; if (bus.output_valid !== 1'b1 || bus.rs_id_out !== 5'd1 || bus.op1_out !== 32'h11) begin failures++; $display("FAIL hold_%0d: got v=%0b id=%0d op1=%0h want 1 1 11", c, bus.output_valid, bus.rs_id_out, bus.op1_out); end
         tick();
      end
      cdb(5'd2, 32'h0, 32'h0);
      checks++; if (dbg[2] !== ST_WAIT) begin failures++; $display("FAIL wait_own_tag: got %0d want 1", dbg[2]); end
      cdb(5'd12, 32'hC0, 32'h0);
      checks++; if (bus.rs_id_out !== 5'd0 || bus.op1_out !== 32'hC0) begin failures++; $display("FAIL preempt: got id=%0d op1=%0h want 0 c0", bus.rs_id_out, bus.op1_out); end
      bus.output_ready = 1'b1;
      tick();
      checks++; if (dbg[0] !== ST_ISSUED || bus.rs_id_out !== 5'd1) begin failures++; $display("FAIL preempt_accept: got st=%0d id=%0d want 2 1", dbg[0], bus.rs_id_out); end
      tick();
      tick();
      checks++; if (bus.output_valid !== 1'b0) begin failures++; $display("FAIL hold_empty: got %0b want 0", bus.output_valid); end
      cdb(5'd13, 32'hD0, 32'h0);
      checks++; if (bus.rs_id_out !== 5'd2 || bus.op1_out !== 32'hD0) begin failures++; $display("FAIL late_wake: got id=%0d op1=%0h want 2 d0", bus.rs_id_out, bus.op1_out); end
      tick();
      for (int i = 0; i < 4; i++) cdb(5'(i), 32'h0, 32'h0);
      checks++; if (dbg !== ALL_FREE) begin failures++; $display("FAIL hold_cleanup: got %0h want 0", dbg); end
   endtask

   task automatic test_reset_mid();
      bus.output_ready = 1'b0;
      alloc(32'h60, 1'b1, 5'd0,  32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd6, ctl_add);
      alloc(32'd0,  1'b0, 5'd20, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd7, ctl_add);
      bus.output_ready = 1'b1;
      tick();
      bus.output_ready = 1'b0;
      alloc(32'd0,  1'b0, 5'd21, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd8, ctl_add);
      checks++; if (dbg !== 8'h16) begin failures++; $display("FAIL mid_setup: got %0h want 16", dbg); end
      rst = 1'b1;
      #1;
      checks++; if (bus.input_ready !== 1'b0 || bus.output_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_ports: got rdy=%0b v=%0b want 0 0", bus.input_ready, bus.output_valid); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (bus.input_ready !== 1'b1 || bus.output_valid !== 1'b0 || dbg !== ALL_FREE) begin failures++; $display("FAIL mid_after: got rdy=%0b v=%0b st=%0h want 1 0 0", bus.input_ready, bus.output_valid, dbg); end
      cdb(5'd0, 32'h0, 32'h0);
      cdb(5'd20, 32'h77, 32'h0);
      checks++; if (dbg !== ALL_FREE || bus.output_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_cdb: got st=%0h v=%0b want 0 0", dbg, bus.output_valid); end
      bus.output_ready = 1'b1;
      alloc(32'h61, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 5'd6, ctl_add);
      checks++; if (bus.rs_id_out !== 5'd0 || bus.op1_out !== 32'h61) begin failures++; $display("FAIL mid_reuse: got id=%0d op1=%0h want 0 61", bus.rs_id_out, bus.op1_out); end
      tick();
      cdb(5'd0, 32'h0, 32'h0);
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      ctl_add = '{subtract: 1'b0, carry_in: 1'b0, set_ca: 1'b1, set_ov: 1'b0, set_cr0: 1'b1};
      ctl_sub = '{subtract: 1'b1, carry_in: 1'b0, set_ca: 1'b1, set_ov: 1'b1, set_cr0: 1'b0};
      test_reset();
      test_basic();
      test_wakeup();
      test_bypass();
      test_full_order();
      test_hold_priority();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
